// File: rtl/chip8_framebuffer.sv
// CHIP-8 pixel store: per-pixel XOR draw port, whole-screen clear engine and a
// row-by-row scan-out stream to a display sink over a valid/ready handshake.
module chip8_framebuffer #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               gfxAddr,
  input  logic                      gfxEn,
  input  logic                      gfxFlip,
  output logic                      gfxVal,
  input  logic                      clearReq,
  output logic                      clearBusy,
  input  logic                      frameReq,
  output logic                      rowValid,
  input  logic                      rowReady,
  output logic [WIDTH-1:0]          rowData,
  output logic [$clog2(HEIGHT)-1:0] rowIdx,
  output logic                      frameDone
);

  localparam int unsigned ColW  = $clog2(WIDTH);
  localparam int unsigned RowW  = $clog2(HEIGHT);
  localparam int unsigned AddrW = ColW + RowW;
  localparam logic [RowW-1:0] LastRow = RowW'(HEIGHT - 1);

  typedef enum logic {CIdle, CRun} clr_state_e;
  typedef enum logic {SIdle, SRow} scan_state_e;

  // Pixel storage, one word per row
  logic [WIDTH-1:0] mem_q [HEIGHT];

  // Address decode; bits above the frame size are ignored so addresses wrap
  logic [RowW-1:0] pix_row;
  logic [ColW-1:0] pix_col;
  logic            unused_addr_bits;

  assign pix_col          = gfxAddr[ColW-1:0];
  assign pix_row          = gfxAddr[AddrW-1:ColW];
  assign unused_addr_bits = ^gfxAddr[15:AddrW];

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  clr_state_e      clr_state_q, clr_state_d;
  logic [RowW-1:0] clr_ptr_q, clr_ptr_d;
  logic            clr_wr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_state_q <= CIdle;
      clr_ptr_q   <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_ptr_q   <= clr_ptr_d;
    end
  end

  always_comb begin
    clr_state_d = clr_state_q;
    clr_ptr_d   = clr_ptr_q;
    unique case (clr_state_q)
      CIdle: begin
        if (clearReq) begin
          clr_state_d = CRun;
          clr_ptr_d   = '0;
        end
      end
      CRun: begin
        // A repeated clearReq here does not restart the sweep
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastRow) begin
          clr_state_d = CIdle;
          clr_ptr_d   = '0;
        end
      end
      default: clr_state_d = CIdle;
    endcase
  end

  always_comb begin
    clearBusy = (clr_state_q == CRun);
    clr_wr    = (clr_state_q == CRun);
  end

  // ---------------------------------------------------------------------------
  // Pixel array and draw port
  // ---------------------------------------------------------------------------
  logic flip_en;

  assign flip_en = gfxEn & gfxFlip & ~clearBusy;
  assign gfxVal  = clearBusy ? 1'b0 : mem_q[pix_row][pix_col];

  // Clear and flip never target the same cycle: flips are dropped while busy
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < HEIGHT; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      if (clr_wr) begin
        mem_q[clr_ptr_q] <= '0;
      end
      if (flip_en) begin
        mem_q[pix_row][pix_col] <= ~mem_q[pix_row][pix_col];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-out engine
  // ---------------------------------------------------------------------------
  scan_state_e      scan_state_q, scan_state_d;
  logic [RowW-1:0]  row_idx_q, row_idx_d;
  logic [WIDTH-1:0] row_data_q, row_data_d;
  logic             frame_done_q, frame_done_d;
  logic             row_accept;
  logic             row_last;
  logic [RowW-1:0]  row_idx_next;

  assign row_accept   = (scan_state_q == SRow) & rowReady;
  assign row_last     = (row_idx_q == LastRow);
  assign row_idx_next = row_idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_state_q <= SIdle;
      row_idx_q    <= '0;
      row_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      scan_state_q <= scan_state_d;
      row_idx_q    <= row_idx_d;
      row_data_q   <= row_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row words are captured from the array's current contents, so a flip or
  // clear landing on the same edge is not yet visible in the loaded row.
  always_comb begin
    scan_state_d = scan_state_q;
    row_idx_d    = row_idx_q;
    row_data_d   = row_data_q;
    frame_done_d = 1'b0;
    unique case (scan_state_q)
      SIdle: begin
        if (frameReq) begin
          scan_state_d = SRow;
          row_idx_d    = '0;
          row_data_d   = mem_q[0];
        end
      end
      SRow: begin
        if (row_accept) begin
          if (row_last) begin
            scan_state_d = SIdle;
            frame_done_d = 1'b1;
          end else begin
            row_idx_d  = row_idx_next;
            row_data_d = mem_q[row_idx_next];
          end
        end
      end
      default: scan_state_d = SIdle;
    endcase
  end

  always_comb begin
    rowValid  = (scan_state_q == SRow);
    rowIdx    = row_idx_q;
    rowData   = row_data_q;
    frameDone = frame_done_q;
  end

endmodule
